// File: rtl/shake_core_arbiter.sv
// -----------------------------------------------------------------------------
// shake_core_arbiter
//
// Round-robin arbiter that shares one SHAKE256 hash core between NUM_REQ
// requesters. A winner is picked from the pending requests, the core gets a
// one-cycle start pulse, and the arbiter then waits for the core to finish.
// The owner receives a one-cycle done pulse, or an err pulse if the core
// overflowed or the watchdog expired. After that the core is released.
// When the watchdog expires, the core also receives a one-cycle abort pulse
// so that it soft-resets.
//
// Ports
//   clk             in   1        system clock, rising edge
//   reset_n         in   1        asynchronous, active-low reset
//   req             in   NUM_REQ  level request per requester, held until done/err
//   gnt             out  NUM_REQ  one-hot owner of the core, all-zero when free
//   core_start      out  1        one-cycle start pulse to the core
//   core_abort      out  1        one-cycle soft-reset pulse on watchdog expiry
//   core_done       in   1        core completion (first high cycle in WAIT counts)
//   core_overflow   in   1        core input-overflow flag, sampled with core_done
//   done            out  NUM_REQ  one-cycle completion pulse to the owner
//   err             out  NUM_REQ  one-cycle error pulse to the owner
//   busy            out  1        high whenever the FSM is not idle
//   debug_arb_state out  2        current FSM state
// -----------------------------------------------------------------------------
module shake_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               core_start,
    output logic               core_abort,
    input  logic               core_done,
    input  logic               core_overflow,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               busy,
    output logic [1:0]         debug_arb_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    arb_state_t         state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [PTR_W-1:0]   owner, owner_next;
    logic [WD_W-1:0]    watchdog, watchdog_next;
    logic [NUM_REQ-1:0] gnt_next, done_next, err_next;
    logic               core_start_next, core_abort_next;

    logic               found;
    logic [PTR_W-1:0]   winner;

    // Round-robin search: the first pending request at or above ptr wins,
    // and the search wraps from NUM_REQ-1 back to 0.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and output logic. The pulse outputs default to zero, so
    // each pulse lasts exactly one cycle. The grant holds its value unless a
    // state explicitly changes it.
    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        owner_next      = owner;
        watchdog_next   = watchdog;
        gnt_next        = gnt;
        done_next       = '0;
        err_next        = '0;
        core_start_next = 1'b0;
        core_abort_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_next        = ONE_HOT0 << winner;
                    owner_next      = winner;
                    core_start_next = 1'b1;
                    state_next      = START;
                end
            end
            START: begin
                // A core_done seen here cannot belong to this job, so it is ignored.
                watchdog_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a watchdog expiry on the same cycle.
                if (core_done) begin
                    done_next[owner] = ~core_overflow;
                    err_next[owner]  = core_overflow;
                    state_next       = RELEASE;
                end else if (watchdog == WD_LIMIT) begin
                    err_next[owner] = 1'b1;
                    core_abort_next = 1'b1;
                    state_next      = RELEASE;
                end else begin
                    watchdog_next = watchdog + WD_W'(1);
                end
            end
            RELEASE: begin
                gnt_next   = '0;
                ptr_next   = (owner == LAST_REQ) ? '0 : owner + PTR_W'(1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. A reset in the middle of a job discards the
    // job silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            watchdog   <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            core_start <= 1'b0;
            core_abort <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            owner      <= owner_next;
            watchdog   <= watchdog_next;
            gnt        <= gnt_next;
            done       <= done_next;
            err        <= err_next;
            core_start <= core_start_next;
            core_abort <= core_abort_next;
        end
    end

    assign busy            = (state != IDLE);
    assign debug_arb_state = state;

endmodule
